// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, state encoding and sum-width helper for input_mac_accum
package mac_pkg;

    localparam int LANES    = 10;
    localparam int LANE_W   = 16;
    localparam int WGT_W    = 8;
    localparam int NUM_COLS = 10;
    localparam int ACC_W    = 32;

    // Product carries one extra bit so the zero-extended lane stays positive as a signed operand
    function automatic int prod_width(input int lane_w, input int wgt_w);
        return lane_w + wgt_w + 1;
    endfunction

    function automatic int sum_width(input int lanes, input int lane_w, input int wgt_w);
        return prod_width(lane_w, wgt_w) + $clog2(lanes);
    endfunction

    localparam int SUM_W = sum_width(LANES, LANE_W, WGT_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/input_mac_accum_lane_dot.sv
// rtl/input_mac_accum_lane_dot.sv - combinational dot product of one column word with its weights
module lane_dot
    import mac_pkg::*;
#(
    parameter int LANES  = mac_pkg::LANES,
    parameter int LANE_W = mac_pkg::LANE_W,
    parameter int WGT_W  = mac_pkg::WGT_W,
    parameter int SUM_W  = sum_width(LANES, LANE_W, WGT_W)
) (
    input  logic [LANES*LANE_W-1:0] i_col_data,
    input  logic [LANES*WGT_W-1:0]  i_wgt_data,
    output logic signed [SUM_W-1:0] o_sum
);

    localparam int PROD_W = prod_width(LANE_W, WGT_W);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0]  w_acc;

    always_comb begin
        w_prod = '0;
        w_acc  = '0;
        for (int i = 0; i < LANES; i++) begin
            // Full lane width is used; upper lane bits are deliberately not masked
            w_prod = $signed({1'b0, i_col_data[i*LANE_W +: LANE_W]})
                   * $signed(i_wgt_data[i*WGT_W +: WGT_W]);
            w_acc  = w_acc + {{(SUM_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/input_mac_accum.sv
// rtl/input_mac_accum.sv - accumulates lane dot products over NUM_COLS columns into one signed result
module input_mac_accum
    import mac_pkg::*;
#(
    parameter int LANES    = mac_pkg::LANES,
    parameter int LANE_W   = mac_pkg::LANE_W,
    parameter int WGT_W    = mac_pkg::WGT_W,
    parameter int NUM_COLS = mac_pkg::NUM_COLS,
    parameter int ACC_W    = mac_pkg::ACC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          col_valid,
    input  logic [LANES*LANE_W-1:0]       col_data,
    input  logic [LANES*WGT_W-1:0]        wgt_data,
    output logic                          col_ready,
    output logic [$clog2(NUM_COLS+1)-1:0] col_idx,
    output logic                          busy,
    output logic signed [ACC_W-1:0]       result,
    output logic                          result_valid
);

    localparam int SUM_W  = sum_width(LANES, LANE_W, WGT_W);
    localparam int CIDX_W = $clog2(NUM_COLS + 1);
    localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_COLS - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CIDX_W-1:0]        r_col_idx;
    logic signed [SUM_W-1:0]  r_sum_reg;
    logic                     r_sum_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_result;
    logic                     r_result_valid;

    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_sum_ext;
    logic                     w_accept;

    lane_dot #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .WGT_W  (WGT_W),
        .SUM_W  (SUM_W)
    ) u_lane_dot (
        .i_col_data (col_data),
        .i_wgt_data (wgt_data),
        .o_sum      (w_sum)
    );

    assign w_sum_ext = {{(ACC_W-SUM_W){r_sum_reg[SUM_W-1]}}, r_sum_reg};
    assign w_accept  = col_valid && (r_state == ST_RUN);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (w_accept && (r_col_idx == LAST_IDX)) w_state_next = ST_FLUSH;
            ST_FLUSH: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_col_idx      <= '0;
            r_sum_reg      <= '0;
            r_sum_vld      <= 1'b0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_result_valid <= 1'b0;
            // Stage 2: fold the previous beat's sum in, whatever the state
            if (r_sum_vld) begin
                r_acc <= r_acc + w_sum_ext;
            end
            case (r_state)
                ST_IDLE: begin
                    r_sum_vld <= 1'b0;
                    if (start) begin
                        r_acc     <= '0;
                        r_col_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_sum_reg <= w_sum;
                        r_sum_vld <= 1'b1;
                        r_col_idx <= r_col_idx + CIDX_W'(1);
                    end else begin
                        r_sum_vld <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_result       <= r_acc + w_sum_ext;
                    r_result_valid <= 1'b1;
                    r_sum_vld      <= 1'b0;
                end
                default: begin
                    r_sum_vld <= 1'b0;
                end
            endcase
        end
    end

    assign col_ready    = (r_state == ST_RUN);
    assign busy         = (r_state != ST_IDLE);
    assign col_idx      = r_col_idx;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_input_mac_accum.sv
// tb/tb_input_mac_accum.sv - directed scoreboard bench for input_mac_accum
module tb_input_mac_accum;

    localparam int LANES    = 10;
    localparam int LANE_W   = 16;
    localparam int WGT_W    = 8;
    localparam int NUM_COLS = 10;
    localparam int ACC_W    = 32;
    localparam int CIDX_W   = $clog2(NUM_COLS + 1);

    logic                          clk;
    logic                          rst_n;
    logic                          start;
    logic                          col_valid;
    logic [LANES*LANE_W-1:0]       col_data;
    logic [LANES*WGT_W-1:0]        wgt_data;
    logic                          col_ready;
    logic [CIDX_W-1:0]             col_idx;
    logic                          busy;
    logic signed [ACC_W-1:0]       result;
    logic                          result_valid;

    int     n_checks = 0;
    int     n_errors = 0;
    int     n_pulses = 0;
    longint exp_q[$];

    input_mac_accum #(
        .LANES    (LANES),
        .LANE_W   (LANE_W),
        .WGT_W    (WGT_W),
        .NUM_COLS (NUM_COLS),
        .ACC_W    (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .col_valid    (col_valid),
        .col_data     (col_data),
        .wgt_data     (wgt_data),
        .col_ready    (col_ready),
        .col_idx      (col_idx),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check("stale_pulse", 1, 0);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_beat(input int mode, input int lval, input int wval, output longint dot);
        dot = 0;
        for (int i = 0; i < LANES; i++) begin
            int lane;
            lane = (mode == 1) ? i : lval;
            col_data[i*LANE_W +: LANE_W] = LANE_W'(lane);
            wgt_data[i*WGT_W +: WGT_W]   = WGT_W'(wval);
            dot += longint'(lane) * longint'(wval);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Feeds NUM_COLS beats; returns at the negedge where result_valid should be high
    task automatic feed(input int mode, input int lval, input int wval, input int gap, input bit noisy);
        longint exp_acc;
        longint dot;
        exp_acc = 0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int g = 0; g < gap; g++) begin
                col_valid = 1'b0;
                start     = noisy;
                tick();
                check("col_idx_gap", col_idx, c);
            end
            set_beat(mode, lval, wval, dot);
            col_valid = 1'b1;
            start     = noisy;
            check("col_ready_run", col_ready, 1);
            check("col_idx_beat", col_idx, c);
            exp_acc += dot;
            tick();
        end
        col_valid = 1'b0;
        check("rv_in_flush", result_valid, 0);
        check("col_ready_flush", col_ready, 0);
        exp_q.push_back(exp_acc);
        tick();
        start = 1'b0;
        check("rv_latency", result_valid, 1);
        check("busy_done", busy, 0);
    endtask

    initial begin
        longint dot;
        rst_n     = 1'b0;
        start     = 1'b0;
        col_valid = 1'b0;
        col_data  = '0;
        wgt_data  = '0;
        tick();
        tick();
        check("rst_result", result, 0);
        check("rst_rv", result_valid, 0);
        check("rst_ready", col_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", col_idx, 0);

        rst_n = 1'b1;
        set_beat(0, 1, 1, dot);
        col_valid = 1'b1;
        repeat (3) tick();
        check("idle_ready", col_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_idx", col_idx, 0);
        check("idle_rv", result_valid, 0);
        col_valid = 1'b0;

        start_run();
        feed(0, 1, 1, 0, 1'b0);
        tick();
        check("rv_one_cycle", result_valid, 0);
        check("result_hold", result, 100);

        start_run();
        feed(0, 511, -128, 0, 1'b0);
        tick();

        start_run();
        feed(1, 0, 2, 2, 1'b0);
        tick();
        check("gap_result_hold", result, 900);

        start_run();
        feed(0, 65535, 127, 0, 1'b0);
        tick();

        start_run();
        feed(0, 1, 1, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_rv_busy", busy, 1);
        check("prev_result_held", result, 100);
        feed(0, 3, -1, 1, 1'b0);
        tick();

        start_run();
        for (int c = 0; c < 5; c++) begin
            set_beat(0, 7, 5, dot);
            col_valid = 1'b1;
            tick();
        end
        col_valid = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_idx", col_idx, 0);
        check("abort_rv", result_valid, 0);
        repeat (3) tick();
        start_run();
        feed(0, 1, 1, 0, 1'b0);
        tick();
        repeat (2) tick();

        check("pulse_count", n_pulses, 7);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/input_mac_accum.md
# input_mac_accum

Neuron dot-product stage directly downstream of the input column SRAM. Each beat consumes the SRAM's 160-bit column word (10 lanes of 16-bit zero-extended 9-bit pixels) plus a matching 80-bit weight word (10 signed 8-bit weights), forms the lane dot product, and accumulates it over NUM_COLS columns. It then presents one signed result with a single-cycle valid pulse. Output feeds the activation/compare stage.

## Interface
- LANES, 10, pixel lanes per column word
- LANE_W, 16, bits per lane in col_data (unsigned)
- WGT_W, 8, bits per signed weight
- NUM_COLS, 10, columns accumulated per result (≥1)
- ACC_W, 32, accumulator/result width (signed)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin a new accumulation (honoured in IDLE only)
- col_valid  input  1  col_data/wgt_data valid this cycle
- col_data  input  LANES*LANE_W  lane i at [i*LANE_W +: LANE_W]
- wgt_data  input  LANES*WGT_W  signed weight i at [i*WGT_W +: WGT_W]
- col_ready  output  1  block accepts a beat this cycle
- col_idx  output  $clog2(NUM_COLS+1)  index of next column expected (drives weight/SRAM address)
- busy  output  1  state != IDLE
- result  output  ACC_W  signed accumulated dot product, held until next completion
- result_valid  output  1  one-cycle pulse, result is new

## Operation
- Reset (rst_n=0 at an edge): state IDLE; col_idx, acc, sum_reg, sum_vld, result, result_valid all 0. Reset mid-run aborts; partial sum discarded, no result_valid.
- States: IDLE, RUN, FLUSH.
- IDLE: col_ready=0. start=1 → acc<=0, col_idx<=0, sum_vld<=0, → RUN.
- RUN: col_ready=1. Beat accepted when col_valid&col_ready. On accept: sum_reg<=Σ zext(lane_i)*sext(w_i), sum_vld<=1, col_idx++. If col_idx==NUM_COLS-1 at accept → FLUSH. No accept → sum_vld<=0, idle cycle tolerated indefinitely.
- Each edge with sum_vld=1: acc<=acc+sum_reg (stage 2), independent of state.
- FLUSH (exactly 1 cycle): col_ready=0; result<=acc+sum_reg, result_valid<=1, → IDLE.
- result_valid cleared on the edge after it was set; result holds.
- start while busy ignored. start in the result_valid cycle (now IDLE) accepted normally; result unchanged until next completion.
- Arithmetic: lane unsigned LANE_W, weight two's-complement WGT_W; product LANE_W+WGT_W+1 signed; sum_reg LANE_W+WGT_W+1+$clog2(LANES) signed, sign-extended into ACC_W. No saturation; defaults cannot overflow (|max| = 65535·128·10·10 < 2^31). Upper 7 bits of each lane are not masked.

## Timing
- Throughput: one column per cycle while col_valid held high.
- Latency: last beat accepted at edge T → result, result_valid=1 after edge T+1, result_valid=0 after edge T+2.
- Minimum run: NUM_COLS+2 cycles from start edge to IDLE.
- col_ready is registered-state decoded (no combinational path from col_valid).
- col_idx updates on the accepting edge; weight memory must present wgt_data for col_idx in the same cycle as col_valid.

## Structure
- Shared package mac_pkg: LANES, LANE_W, WGT_W, ACC_W defaults, SUM_W derivation, state encoding constants (IDLE=0, RUN=1, FLUSH=2).
- One combinational sub-module lane_dot: col_data, wgt_data → signed SUM_W sum; top holds FSM, counter, sum_reg, acc, result regs.

## Test plan
- Reset/idle: rst_n low 2 cycles → all outputs 0; col_valid=1 with no start → col_ready=0, no accumulation.
- All lanes=1, all weights=1, 10 back-to-back beats → result=100, result_valid one cycle exactly 1 edge after 10th accept.
- Lanes=511, weights=-128, 10 beats → result=-6,540,800; sign handling verified.
- Gapped valid (accept every 3rd cycle), lane_i=i, weights=2 → result=900; col_idx steps 0..9 only on accepts.
- start pulsed during RUN and FLUSH → ignored; start in result_valid cycle → new run, previous result held until its completion.
- rst_n low at column 5, then new start with lanes=1/weights=1 → result=100, no stale pulse.
